// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - shared types and helpers for the Ethernet reset sequencer
package eth_pkg;

  // State encoding is also decoded by debug/ILA logic through state_o.
  typedef enum logic [2:0] {
    S_RESET       = 3'd0,
    S_WAIT_LOCK   = 3'd1,
    S_LOCK_STABLE = 3'd2,
    S_PHY_RST     = 3'd3,
    S_PHY_WAKE    = 3'd4,
    S_RUN         = 3'd5
  } eth_rst_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/eth_sync_ff.sv
// rtl/eth_sync_ff.sv - generic N-flop single-bit synchronizer
module eth_sync_ff #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // Shift the asynchronous input through the flop chain; oldest bit is the output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/eth_rst_seq.sv
// rtl/eth_rst_seq.sv - PHY/MAC reset sequencer driven by MMCM lock
module eth_rst_seq
  import eth_pkg::*;
#(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int PHY_RST_CYCLES     = 1250000,
  parameter int PHY_WAKE_CYCLES    = 6250000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk_locked_i,
  input  logic       soft_rst_i,
  output logic       phy_rst_n_o,
  output logic       mac_rst_o,
  output logic       rst_done_o,
  output logic [2:0] state_o
);

  localparam int MAX_N = max3(LOCK_STABLE_CYCLES, PHY_RST_CYCLES, PHY_WAKE_CYCLES);
  localparam int CNT_W = $clog2(MAX_N) + 1;

  localparam logic [CNT_W-1:0] LS_LAST   = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(PHY_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(PHY_WAKE_CYCLES - 1);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("eth_rst_seq: SYNC_STAGES must be >= 2");
  end
  if (LOCK_STABLE_CYCLES < 1 || PHY_RST_CYCLES < 1 || PHY_WAKE_CYCLES < 1) begin : g_bad_cycles
    $error("eth_rst_seq: cycle counts must be >= 1");
  end

  logic            lock_s;
  eth_rst_state_t  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            phy_rst_n_q, phy_rst_n_d;
  logic            mac_rst_q, mac_rst_d;
  logic            rst_done_q, rst_done_d;
  logic            restart;

  eth_sync_ff #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b0)
  ) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (clk_locked_i),
    .q_o   (lock_s)
  );

  // Next state (lock loss > soft request > timeout), counter and output decode.
  always_comb begin
    state_d = state_q;
    restart = 1'b0;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_RESET:     state_d = S_WAIT_LOCK;
      S_WAIT_LOCK: if (lock_s) state_d = S_LOCK_STABLE;
      S_LOCK_STABLE: begin
        if (!lock_s)               state_d = S_WAIT_LOCK;
        else if (cnt_q == LS_LAST) state_d = S_PHY_RST;
      end
      S_PHY_RST: begin
        if (!lock_s) state_d = S_WAIT_LOCK;
        else if (soft_rst_i) restart = 1'b1;
        else if (cnt_q == RST_LAST) state_d = S_PHY_WAKE;
      end
      S_PHY_WAKE: begin
        if (!lock_s) state_d = S_WAIT_LOCK;
        else if (soft_rst_i) state_d = S_PHY_RST;
        else if (cnt_q == WAKE_LAST) state_d = S_RUN;
      end
      S_RUN: begin
        if (!lock_s)         state_d = S_WAIT_LOCK;
        else if (soft_rst_i) state_d = S_PHY_RST;
      end
      default: state_d = S_RESET;
    endcase

    // Timed states count up from zero; untimed states keep the counter parked at zero.
    if (state_d != state_q || restart) begin
      cnt_d = '0;
    end else if (state_q == S_LOCK_STABLE || state_q == S_PHY_RST || state_q == S_PHY_WAKE) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    phy_rst_n_d = (state_d == S_PHY_WAKE) || (state_d == S_RUN);
    mac_rst_d   = (state_d != S_RUN);
    rst_done_d  = (state_d == S_RUN);
  end

  // State, counter and registered outputs; reset forces every output to its safe value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_RESET;
      cnt_q       <= '0;
      phy_rst_n_q <= 1'b0;
      mac_rst_q   <= 1'b1;
      rst_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      phy_rst_n_q <= phy_rst_n_d;
      mac_rst_q   <= mac_rst_d;
      rst_done_q  <= rst_done_d;
    end
  end

  assign phy_rst_n_o = phy_rst_n_q;
  assign mac_rst_o   = mac_rst_q;
  assign rst_done_o  = rst_done_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_eth_rst_seq.sv
// tb/tb_eth_rst_seq.sv - scoreboard bench for eth_rst_seq with a phase/countdown reference model
module tb_eth_rst_seq;

  localparam int SS   = 2;
  localparam int LS   = 4;
  localparam int PR   = 8;
  localparam int PW   = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clk_locked_i = 1'b0;
  logic       soft_rst_i = 1'b0;
  logic       phy_rst_n_o;
  logic       mac_rst_o;
  logic       rst_done_o;
  logic [2:0] state_o;

  typedef struct packed {
    logic       phy;
    logic       mac;
    logic       done;
    logic [2:0] st;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model: phase number, cycles left in the phase, raw lock history.
  int   phase = 0;
  int   remain = 0;
  bit   hist[$];

  eth_rst_seq #(
    .SYNC_STAGES        (SS),
    .LOCK_STABLE_CYCLES (LS),
    .PHY_RST_CYCLES     (PR),
    .PHY_WAKE_CYCLES    (PW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clk_locked_i (clk_locked_i),
    .soft_rst_i   (soft_rst_i),
    .phy_rst_n_o  (phy_rst_n_o),
    .mac_rst_o    (mac_rst_o),
    .rst_done_o   (rst_done_o),
    .state_o      (state_o)
  );

  always #5 clk = ~clk;

  function automatic exp_t expected_now();
    exp_t e;
    e.phy  = (phase == 4 || phase == 5);
    e.mac  = (phase != 5);
    e.done = (phase == 5);
    e.st   = 3'(phase);
    return e;
  endfunction

  function automatic int dur(input int p);
    return (p == 2) ? LS : (p == 3) ? PR : PW;
  endfunction

  task automatic model_step(input bit lk, input bit sf);
    bit ls;
    if (!rst_n) begin
      phase = 0;
      remain = 0;
      hist.delete();
      return;
    end
    ls = (hist.size() >= SS) ? hist[hist.size() - SS] : 1'b0;
    hist.push_back(lk);
    if (hist.size() > SS) void'(hist.pop_front());
    if (phase == 0) begin
      phase = 1;
    end else if (phase >= 2 && !ls) begin
      phase = 1;
    end else if (phase >= 3 && sf) begin
      phase = 3; remain = PR;
    end else if (phase == 1) begin
      if (ls) begin phase = 2; remain = LS; end
    end else if (phase >= 2 && phase <= 4) begin
      remain = remain - 1;
      if (remain == 0) begin
        phase = phase + 1;
        if (phase <= 4) remain = dur(phase);
      end
    end
  endtask

  task automatic cycle(input bit lk, input bit sf);
    clk_locked_i = lk;
    soft_rst_i   = sf;
    @(posedge clk);
    model_step(lk, sf);
    exp_q.push_back(expected_now());
    @(negedge clk);
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
    end
  endtask

  // Asserts rst_n between edges and checks the outputs react without any clock edge.
  task automatic async_reset(input int hold_cycles, input bit lk);
    #1 rst_n = 1'b0;
    #1;
    chk("async_phy_rst_n", phy_rst_n_o, 0);
    chk("async_mac_rst", mac_rst_o, 1);
    chk("async_rst_done", rst_done_o, 0);
    chk("async_state", state_o, 0);
    phase = 0; remain = 0; hist.delete();
    for (int i = 0; i < hold_cycles; i++) cycle(lk, 1'b0);
    rst_n = 1'b1;
  endtask

  // Monitor: every cycle the DUT presents outputs, compare against the oldest expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("phy_rst_n_o", phy_rst_n_o, e.phy);
      chk("mac_rst_o", mac_rst_o, e.mac);
      chk("rst_done_o", rst_done_o, e.done);
      chk("state_o", state_o, e.st);
    end
  end

  initial begin
    // Power-up with clock running and rst_n low.
    @(negedge clk);
    chk("pwr_phy_rst_n", phy_rst_n_o, 0);
    chk("pwr_mac_rst", mac_rst_o, 1);
    chk("pwr_rst_done", rst_done_o, 0);
    chk("pwr_state", state_o, 0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0);
    rst_n = 1'b1;

    // Nominal sequence to RUN.
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0);
    for (int i = 0; i < 26; i++) cycle(1'b1, 1'b0);

    // Lock loss in RUN, then a glitch during lock-stable, then relock.
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0);
    for (int i = 0; i < 26; i++) cycle(1'b1, 1'b0);

    // Soft reset in RUN, second pulse during PHY reset, then held high.
    cycle(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b1);
    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0);
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b1);
    for (int i = 0; i < 18; i++) cycle(1'b1, 1'b0);

    // Lock loss and soft request on the same cycle, then relock.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1);
    for (int i = 0; i < 25; i++) cycle(1'b1, 1'b0);

    // Reset during PHY wake with lock held, then nominal from release.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1);
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0);
    async_reset(2, 1'b1);
    for (int i = 0; i < 25; i++) cycle(1'b1, 1'b0);

    // Randomized mix of lock drops, soft pulses and resets.
    begin
      bit lk;
      int drop;
      lk = 1'b1;
      drop = 0;
      for (int i = 0; i < 3000; i++) begin
        if (drop > 0) begin
          drop--;
          lk = 1'b0;
        end else if ($urandom_range(0, 199) == 0) begin
          drop = $urandom_range(1, 6);
          lk = 1'b0;
        end else begin
          lk = 1'b1;
        end
        if ($urandom_range(0, 599) == 0) async_reset($urandom_range(1, 3), lk);
        cycle(lk, ($urandom_range(0, 59) == 0));
      end
    end

    @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
